// File: rtl/mux_pkg.sv
// Shared select encodings for the register-file read-path selector cells.
package mux_pkg;

  typedef enum logic [1:0] {
    SEL_I00 = 2'b00,
    SEL_I01 = 2'b01,
    SEL_I10 = 2'b10,
    SEL_I11 = 2'b11
  } sel_e;

endpackage

// File: rtl/mux2_to_1.sv
// WIDTH-bit 2:1 selector; the conditional operator keeps X on differing bits
// when sel is unknown instead of silently picking a side.
module mux2_to_1 #(
  parameter int WIDTH = 1
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sel,
  output logic [WIDTH-1:0] y
);

  assign y = sel ? b : a;

endmodule

// File: rtl/mux4_to_1.sv
// 4:1 selector leaf cell: two-level 2:1 tree for a zero-latency output plus
// a registered copy cleared asynchronously by reset_n.
module mux4_to_1
  import mux_pkg::*;
#(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] i00,
  input  logic [WIDTH-1:0] i01,
  input  logic [WIDTH-1:0] i10,
  input  logic [WIDTH-1:0] i11,
  input  logic [1:0]       sel,
  output logic [WIDTH-1:0] out,
  output logic [WIDTH-1:0] out_q
);

  logic [WIDTH-1:0] lo_pair;
  logic [WIDTH-1:0] hi_pair;
  logic [WIDTH-1:0] out_d;

  // sel[0] resolves within each pair, sel[1] picks between pair results
  mux2_to_1 #(.WIDTH(WIDTH)) u_lo_pair (
    .a   (i00),
    .b   (i01),
    .sel (sel[0]),
    .y   (lo_pair)
  );

  mux2_to_1 #(.WIDTH(WIDTH)) u_hi_pair (
    .a   (i10),
    .b   (i11),
    .sel (sel[0]),
    .y   (hi_pair)
  );

  mux2_to_1 #(.WIDTH(WIDTH)) u_root (
    .a   (lo_pair),
    .b   (hi_pair),
    .sel (sel[1]),
    .y   (out_d)
  );

  assign out = out_d;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_q <= '0;
    end else begin
      out_q <= out_d;
    end
  end

endmodule

// File: tb/tb_mux4_to_1.sv
// Bench for mux4_to_1: vector tables, reset corner cases, randomized traffic
// against an array-indexed reference, and a 16:1 tree built from five cells.
module tb_mux4_to_1;
  import mux_pkg::*;

  logic       clk;
  logic       reset_n;

  logic [7:0] i00_8, i01_8, i10_8, i11_8;
  logic [1:0] sel_8;
  logic [7:0] out_8, out_q_8;

  logic       i00_1, i01_1, i10_1, i11_1;
  logic [1:0] sel_1;
  logic       out_1, out_q_1;

  logic [15:0] tree_in;
  logic [3:0]  sel4;
  logic [3:0]  leaf_out;
  logic [3:0]  leaf_q;
  logic        tree_out, tree_q;

  int errors;
  int checks;

  mux4_to_1 #(.WIDTH(8)) u_dut8 (
    .clk     (clk),
    .reset_n (reset_n),
    .i00     (i00_8),
    .i01     (i01_8),
    .i10     (i10_8),
    .i11     (i11_8),
    .sel     (sel_8),
    .out     (out_8),
    .out_q   (out_q_8)
  );

  mux4_to_1 #(.WIDTH(1)) u_dut1 (
    .clk     (clk),
    .reset_n (reset_n),
    .i00     (i00_1),
    .i01     (i01_1),
    .i10     (i10_1),
    .i11     (i11_1),
    .sel     (sel_1),
    .out     (out_1),
    .out_q   (out_q_1)
  );

  // 16:1 bit selector: four leaves on sel4[1:0], one root on sel4[3:2]
  for (genvar k = 0; k < 4; k++) begin : g_leaf
    mux4_to_1 #(.WIDTH(1)) u_leaf (
      .clk     (clk),
      .reset_n (reset_n),
      .i00     (tree_in[4*k]),
      .i01     (tree_in[4*k+1]),
      .i10     (tree_in[4*k+2]),
      .i11     (tree_in[4*k+3]),
      .sel     (sel4[1:0]),
      .out     (leaf_out[k]),
      .out_q   (leaf_q[k])
    );
  end

  mux4_to_1 #(.WIDTH(1)) u_root (
    .clk     (clk),
    .reset_n (reset_n),
    .i00     (leaf_out[0]),
    .i01     (leaf_out[1]),
    .i10     (leaf_out[2]),
    .i11     (leaf_out[3]),
    .sel     (sel4[3:2]),
    .out     (tree_out),
    .out_q   (tree_q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] sel;
    logic       exp_out;
  } vec1_t;

  typedef struct {
    logic [1:0] sel;
    logic [7:0] exp_out;
  } vec8_t;

  vec1_t vec1 [4];
  vec8_t vec8 [4];

  task automatic check_output(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic apply_stimulus(input logic [7:0] a, input logic [7:0] b,
                                input logic [7:0] c, input logic [7:0] d,
                                input logic [1:0] s);
    i00_8 = a;
    i01_8 = b;
    i10_8 = c;
    i11_8 = d;
    sel_8 = s;
  endtask

  // Reference: selected value is simply the input indexed by sel
  function automatic logic [7:0] ref_select(input logic [7:0] d0, input logic [7:0] d1,
                                            input logic [7:0] d2, input logic [7:0] d3,
                                            input logic [1:0] s);
    logic [7:0] bank [4];
    bank[0] = d0;
    bank[1] = d1;
    bank[2] = d2;
    bank[3] = d3;
    return bank[s];
  endfunction

  initial begin
    logic [7:0] d [4];
    logic [1:0] s;
    logic [7:0] expv;
    logic [15:0] pattern;

    errors  = 0;
    checks  = 0;
    reset_n = 1'b0;
    apply_stimulus(8'h11, 8'h22, 8'h33, 8'h44, SEL_I11);
    i00_1 = 1'b0; i01_1 = 1'b1; i10_1 = 1'b1; i11_1 = 1'b0;
    sel_1 = SEL_I00;
    tree_in = 16'h006E;
    sel4 = 4'd0;

    vec1[0] = '{sel: SEL_I00, exp_out: 1'b0};
    vec1[1] = '{sel: SEL_I01, exp_out: 1'b1};
    vec1[2] = '{sel: SEL_I10, exp_out: 1'b1};
    vec1[3] = '{sel: SEL_I11, exp_out: 1'b0};

    vec8[0] = '{sel: SEL_I00, exp_out: 8'hA5};
    vec8[1] = '{sel: SEL_I01, exp_out: 8'h3C};
    vec8[2] = '{sel: SEL_I10, exp_out: 8'hFF};
    vec8[3] = '{sel: SEL_I11, exp_out: 8'h00};

    // Reset state, with clock edges passing while reset is held
    @(posedge clk);
    #1;
    check_output("reset_q8", out_q_8, 8'h00);
    check_output("reset_q1", {7'b0, out_q_1}, 8'h00);
    check_output("reset_out8", out_8, 8'h44);
    @(negedge clk);
    reset_n = 1'b1;

    // WIDTH=1 sweep
    for (int n = 0; n < 4; n++) begin
      sel_1 = vec1[n].sel;
      #1;
      check_output($sformatf("w1_sel%0d", n), {7'b0, out_1}, {7'b0, vec1[n].exp_out});
    end

    // WIDTH=8: immediate out, out_q one edge later
    apply_stimulus(8'hA5, 8'h3C, 8'hFF, 8'h00, SEL_I00);
    for (int n = 0; n < 4; n++) begin
      @(negedge clk);
      sel_8 = vec8[n].sel;
      #1;
      check_output($sformatf("w8_out_sel%0d", n), out_8, vec8[n].exp_out);
      @(posedge clk);
      #1;
      check_output($sformatf("w8_q_sel%0d", n), out_q_8, vec8[n].exp_out);
    end

    // sel=10 held: only i10 matters
    for (int n = 0; n < 6; n++) begin
      @(negedge clk);
      expv = n[0] ? 8'h34 : 8'h12;
      apply_stimulus(8'($urandom), 8'($urandom), expv, 8'($urandom), SEL_I10);
      #1;
      check_output($sformatf("hold10_%0d", n), out_8, expv);
    end

    // Mid-cycle reset clears out_q without an edge; out stays live
    @(negedge clk);
    apply_stimulus(8'h01, 8'h02, 8'hFF, 8'h04, SEL_I10);
    @(posedge clk);
    #1;
    check_output("pre_reset_q", out_q_8, 8'hFF);
    #2;
    reset_n = 1'b0;
    #1;
    check_output("async_clear_q", out_q_8, 8'h00);
    check_output("reset_out_live", out_8, 8'hFF);
    @(negedge clk);
    #1;
    reset_n = 1'b1;
    #1;
    check_output("released_no_edge", out_q_8, 8'h00);
    @(posedge clk);
    #1;
    check_output("reload_q", out_q_8, 8'hFF);

    // Randomized traffic against the indexed reference
    for (int n = 0; n < 150; n++) begin
      @(negedge clk);
      for (int k = 0; k < 4; k++) d[k] = 8'($urandom);
      s = 2'($urandom_range(0, 3));
      apply_stimulus(d[0], d[1], d[2], d[3], s);
      expv = ref_select(d[0], d[1], d[2], d[3], s);
      #1;
      check_output("rand_out", out_8, expv);
      @(posedge clk);
      #1;
      check_output("rand_q", out_q_8, expv);
    end

    // 16:1 tree sweep over the bits of 16'h006E
    pattern = 16'h006E;
    for (int n = 0; n < 16; n++) begin
      sel4 = 4'(n);
      #1;
      check_output($sformatf("tree_idx%0d", n), {7'b0, tree_out}, {7'b0, pattern[n]});
    end

    // Unknown select must not default to i00 (only observable on a 4-state simulator)
    @(negedge clk);
    apply_stimulus(8'h0F, 8'hF0, 8'h0F, 8'hF0, 2'bxx);
    #1;
    if ($isunknown(sel_8)) begin
      check_output("sel_x_out", out_8, 8'hxx);
    end else begin
      $display("[TB] note: 2-state simulator, unknown-select check skipped");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
